// File: rtl/pmu_sleep_sequencer.sv
// Sleep-request sequencer between SoC requesters and the PMU wakeup/power-gating block.
// Ports: clk_i/rstn_i; req_valid_i/req_ready_o/req_msec_i/req_mode_i (per requester);
//        done_valid_o/done_err_o (completion); wen_o/reg_* (wakeup block regs); rstn_pg_i; busy_o.
module pmu_sleep_sequencer #(
  parameter int NREQ         = 2,
  parameter int ACK_TIMEOUT  = 64,
  parameter int MIN_SLEEP_MS = 1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*32-1:0]   req_msec_i,
  input  logic [NREQ*4-1:0]    req_mode_i,
  output logic [NREQ-1:0]      done_valid_o,
  output logic                 done_err_o,
  output logic                 wen_o,
  output logic [31:0]          reg_scratch_o,
  output logic [31:0]          reg_pmu_mode_o,
  output logic                 reg_pmu_en_o,
  input  logic                 rstn_pg_i,
  output logic                 busy_o
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    IDLE, GRANT, WRITE, WAIT_SLEEP, SLEEPING, DONE, ERR
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q;
  logic [31:0]     msec_q;
  logic [3:0]      mode_q;
  logic [CW-1:0]   cnt_q;

  logic [OW-1:0]   sel_idx;
  logic [31:0]     sel_msec;
  logic [3:0]      sel_mode;
  logic            any_req;
  logic            latch_req;
  logic            load_out;
  logic            cnt_clr;
  logic            cnt_inc;

  // Fixed-priority select: scan downward so the lowest active index wins.
  always_comb begin
    sel_idx  = '0;
    sel_msec = '0;
    sel_mode = '0;
    any_req  = |req_valid_i;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        sel_idx  = OW'(i);
        sel_msec = req_msec_i[i*32 +: 32];
        sel_mode = req_mode_i[i*4 +: 4];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    req_ready_o  = '0;
    done_valid_o = '0;
    done_err_o   = 1'b0;
    wen_o        = 1'b0;
    reg_pmu_en_o = 1'b0;
    busy_o       = (state_q != IDLE);
    latch_req    = 1'b0;
    load_out     = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    case (state_q)
      IDLE: begin
        // rstn_pg_i is deliberately not looked at here: a low level while idle is spurious.
        if (any_req) begin
          req_ready_o = NREQ'(1) << sel_idx;
          latch_req   = 1'b1;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        reg_pmu_en_o = 1'b1;
        load_out     = 1'b1;  // data regs become valid together with the WRITE strobe
        state_d      = WRITE;
      end
      WRITE: begin
        reg_pmu_en_o = 1'b1;
        wen_o        = 1'b1;
        cnt_clr      = 1'b1;
        state_d      = WAIT_SLEEP;
      end
      WAIT_SLEEP: begin
        reg_pmu_en_o = 1'b1;
        if (!rstn_pg_i) begin
          state_d = SLEEPING;
        end else begin
          cnt_inc = 1'b1;
          // Compare the incremented value so ERR lands ACK_TIMEOUT cycles after WRITE.
          if (cnt_q + CW'(1) == CW'(ACK_TIMEOUT - 1)) state_d = ERR;
        end
      end
      SLEEPING: begin
        reg_pmu_en_o = 1'b1;
        if (rstn_pg_i) state_d = DONE;
      end
      DONE: begin
        done_valid_o = NREQ'(1) << owner_q;
        state_d      = IDLE;
      end
      ERR: begin
        done_valid_o = NREQ'(1) << owner_q;
        done_err_o   = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q        <= IDLE;
      owner_q        <= '0;
      msec_q         <= '0;
      mode_q         <= '0;
      cnt_q          <= '0;
      reg_scratch_o  <= '0;
      reg_pmu_mode_o <= '0;
    end else begin
      state_q <= state_d;
      if (latch_req) begin
        owner_q <= sel_idx;
        msec_q  <= (sel_msec < 32'(MIN_SLEEP_MS)) ? 32'(MIN_SLEEP_MS) : sel_msec;
        mode_q  <= sel_mode;
      end
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + CW'(1);
      // Held between writes so the wakeup block always sees the last programmed values.
      if (load_out) begin
        reg_scratch_o  <= msec_q;
        reg_pmu_mode_o <= {28'b0, mode_q};
      end
    end
  end

endmodule

// File: tb/tb_pmu_sleep_sequencer.sv
module tb_pmu_sleep_sequencer;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [63:0] req_msec_i;
  logic [7:0]  req_mode_i;
  logic [1:0]  done_valid_o;
  logic        done_err_o;
  logic        wen_o;
  logic [31:0] reg_scratch_o;
  logic [31:0] reg_pmu_mode_o;
  logic        reg_pmu_en_o;
  logic        rstn_pg_i;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  pmu_sleep_sequencer #(.NREQ(2), .ACK_TIMEOUT(64), .MIN_SLEEP_MS(1)) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_msec_i     (req_msec_i),
    .req_mode_i     (req_mode_i),
    .done_valid_o   (done_valid_o),
    .done_err_o     (done_err_o),
    .wen_o          (wen_o),
    .reg_scratch_o  (reg_scratch_o),
    .reg_pmu_mode_o (reg_pmu_mode_o),
    .reg_pmu_en_o   (reg_pmu_en_o),
    .rstn_pg_i      (rstn_pg_i),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 2 time units after the edge.
  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ready"},   32'(req_ready_o),  32'h0);
    check({tag, ".done"},    32'(done_valid_o), 32'h0);
    check({tag, ".err"},     32'(done_err_o),   32'h0);
    check({tag, ".wen"},     32'(wen_o),        32'h0);
    check({tag, ".scratch"}, reg_scratch_o,     32'h0);
    check({tag, ".mode"},    reg_pmu_mode_o,    32'h0);
    check({tag, ".en"},      32'(reg_pmu_en_o), 32'h0);
    check({tag, ".busy"},    32'(busy_o),       32'h0);
  endtask

  initial begin
    rstn_i      = 1'b0;
    req_valid_i = '0;
    req_msec_i  = '0;
    req_mode_i  = '0;
    rstn_pg_i   = 1'b1;
    #12;
    check_all_zero("reset");
    rstn_i = 1'b1;
    step();
    check("idle.busy", 32'(busy_o), 32'h0);

    // Single request from requester 0.
    req_valid_i = 2'b01;
    req_msec_i[31:0] = 32'd5;
    req_mode_i[3:0]  = 4'b0001;
    #1;
    check("single.ready", 32'(req_ready_o), 32'h1);
    step();  // GRANT
    req_valid_i = 2'b00;
    #1;
    check("single.grant_busy", 32'(busy_o), 32'h1);
    check("single.grant_en",   32'(reg_pmu_en_o), 32'h1);
    check("single.grant_wen",  32'(wen_o), 32'h0);
    check("single.grant_rdy",  32'(req_ready_o), 32'h0);
    step();  // WRITE
    check("single.wen",     32'(wen_o), 32'h1);
    check("single.scratch", reg_scratch_o, 32'd5);
    check("single.mode",    reg_pmu_mode_o, 32'd1);
    step();  // WAIT_SLEEP
    check("single.wen_drop", 32'(wen_o), 32'h0);
    check("single.wait_en",  32'(reg_pmu_en_o), 32'h1);
    rstn_pg_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();  // SLEEPING
      check("single.sleep_done", 32'(done_valid_o), 32'h0);
    end
    check("single.sleep_en", 32'(reg_pmu_en_o), 32'h1);
    rstn_pg_i = 1'b1;
    step();  // DONE
    check("single.done", 32'(done_valid_o), 32'h1);
    check("single.err",  32'(done_err_o), 32'h0);
    check("single.en",   32'(reg_pmu_en_o), 32'h0);
    check("single.done_busy", 32'(busy_o), 32'h1);
    step();  // IDLE
    check("single.idle_done", 32'(done_valid_o), 32'h0);
    check("single.idle_busy", 32'(busy_o), 32'h0);
    check("single.hold_scratch", reg_scratch_o, 32'd5);

    // Simultaneous requests; requester 1 carries msec=0 to exercise the clamp.
    req_valid_i = 2'b11;
    req_msec_i  = {32'd0, 32'd7};
    req_mode_i  = {4'b1010, 4'b0011};
    #1;
    check("arb.ready0", 32'(req_ready_o), 32'h1);
    step();  // GRANT req0; req1 keeps holding valid
    req_valid_i = 2'b10;
    #1;
    check("arb.grant_rdy", 32'(req_ready_o), 32'h0);
    step();  // WRITE
    check("arb.scratch", reg_scratch_o, 32'd7);
    check("arb.mode",    reg_pmu_mode_o, 32'd3);
    step();
    rstn_pg_i = 1'b0;
    step();  // SLEEPING
    check("arb.sleep_rdy", 32'(req_ready_o), 32'h0);
    rstn_pg_i = 1'b1;
    step();  // DONE
    check("arb.done",     32'(done_valid_o), 32'h1);
    check("arb.done_rdy", 32'(req_ready_o), 32'h0);
    step();  // IDLE: req1 accepted now
    check("arb.ready1", 32'(req_ready_o), 32'h2);
    step();  // GRANT
    req_valid_i = 2'b00;
    step();  // WRITE
    check("clamp.wen",     32'(wen_o), 32'h1);
    check("clamp.scratch", reg_scratch_o, 32'd1);
    check("clamp.mode",    reg_pmu_mode_o, 32'd10);

    // Timeout: rstn_pg_i stays high; ERR is expected 64 cycles after WRITE.
    step();  // WRITE+1
    check("tmo.wait_en", 32'(reg_pmu_en_o), 32'h1);
    for (int i = 0; i < 62; i++) begin
      step();
      check("tmo.early_done", 32'(done_valid_o), 32'h0);
    end
    step();  // WRITE+64
    check("tmo.done", 32'(done_valid_o), 32'h2);
    check("tmo.err",  32'(done_err_o), 32'h1);
    check("tmo.en",   32'(reg_pmu_en_o), 32'h0);
    check("tmo.busy", 32'(busy_o), 32'h1);
    step();
    check("tmo.idle_busy", 32'(busy_o), 32'h0);
    check("tmo.idle_done", 32'(done_valid_o), 32'h0);

    // Full-scale msec passes unchanged; then reset while SLEEPING.
    req_valid_i = 2'b01;
    req_msec_i  = {32'd0, 32'hFFFF_FFFF};
    req_mode_i  = {4'b0000, 4'b1111};
    step();  // GRANT
    req_valid_i = 2'b00;
    step();  // WRITE
    check("max.scratch", reg_scratch_o, 32'hFFFF_FFFF);
    check("max.mode",    reg_pmu_mode_o, 32'hF);
    step();
    rstn_pg_i = 1'b0;
    step();  // SLEEPING
    check("max.sleep_busy", 32'(busy_o), 32'h1);
    rstn_i = 1'b0;
    #1;
    check_all_zero("midrst");
    #1;
    rstn_i    = 1'b1;
    rstn_pg_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("midrst.no_done", 32'(done_valid_o), 32'h0);
      check("midrst.busy",    32'(busy_o), 32'h0);
    end

    // Spurious rstn_pg_i low while idle.
    rstn_pg_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("spur.busy", 32'(busy_o), 32'h0);
      check("spur.en",   32'(reg_pmu_en_o), 32'h0);
    end
    rstn_pg_i = 1'b1;
    step();
    check("spur.after_busy", 32'(busy_o), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pmu_sleep_sequencer.md
Name: pmu_sleep_sequencer

Overview:
- Sequences the power-mode requests from the SoC into the PMU wakeup/power-gating block.
- Accepts a sleep request (mode and duration) from up to two requesters, FC core and debug, through a fixed-priority arbiter.
- Issues a single-cycle write strobe with the latched scratch (wake time) and mode values.
- Waits for the power-gate domain to assert its reset/ack, then tracks the wakeup and reports completion back to the winning requester.

Parameters:
- NREQ, 2, number of requesters; index 0 has highest priority.
- ACK_TIMEOUT, 64, clk_i cycles to wait for rstn_pg low after a write before flagging an error.
- MIN_SLEEP_MS, 1, minimum allowed sleep duration; smaller requests are clamped up to this value.

Ports:
- clk_i  in  1  32.768 kHz reference clock.
- rstn_i  in  1  asynchronous active-low reset.
- req_valid_i  in  NREQ  per-requester sleep request.
- req_ready_o  out  NREQ  per-requester grant/accept; one-hot or zero.
- req_msec_i  in  NREQ*32  per-requester sleep duration in ms.
- req_mode_i  in  NREQ*4  per-requester PMU mode bits: [0] sleep_op, [1] pd_io, [2] pd_l2, [3] pd_mram.
- done_valid_o  out  NREQ  per-requester completion pulse, 1 cycle.
- done_err_o  out  1  qualifies done_valid_o; 1 means timeout.
- wen_o  out  1  write strobe to the wakeup block, 1 cycle.
- reg_scratch_o  out  32  wake duration driven with wen_o.
- reg_pmu_mode_o  out  32  mode word, zero-extended from 4 bits.
- reg_pmu_en_o  out  1  PMU enable, held high while busy.
- rstn_pg_i  in  1  from the wakeup block; low means sleeping.
- busy_o  out  1  high when the sequencer is not in IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; latched owner, msec and mode registers 0.
- States: IDLE, GRANT, WRITE, WAIT_SLEEP, SLEEPING, DONE, ERR.
- IDLE: if any req_valid_i is set, select the lowest-index active requester. Latch its owner index, msec (clamped to at least MIN_SLEEP_MS) and mode. Assert req_ready_o[owner] for that same cycle (combinational grant). Go to GRANT.
- A valid/ready handshake completes in one cycle. Requests that lose arbitration see ready=0 and must hold valid.
- GRANT: drive reg_pmu_en_o=1 and go to WRITE.
- WRITE: for exactly one cycle, drive wen_o=1 with reg_scratch_o=msec, reg_pmu_mode_o={28'b0,mode} and reg_pmu_en_o=1. Clear the timeout counter. Go to WAIT_SLEEP.
- The data outputs hold their values outside WRITE; they are registered, not zeroed.
- WAIT_SLEEP: if rstn_pg_i=0, go to SLEEPING. Otherwise increment the counter; when counter==ACK_TIMEOUT-1, go to ERR.
- SLEEPING: when rstn_pg_i returns to 1, go to DONE.
- DONE: pulse done_valid_o[owner]=1 with done_err_o=0, drop reg_pmu_en_o, return to IDLE.
- ERR: pulse done_valid_o[owner]=1 with done_err_o=1, drop reg_pmu_en_o, return to IDLE.
- reg_pmu_en_o is 1 in GRANT through SLEEPING and 0 in IDLE, DONE and ERR.
- busy_o is 1 in every state except IDLE.
- Requests arriving while busy are not accepted; req_ready_o=0.
- A new request is arbitrated in the cycle after DONE/ERR at the earliest (IDLE takes one cycle).
- If rstn_pg_i is low while in IDLE (spurious), ignore it.
- Reset mid-operation returns to IDLE with all outputs 0 and no done pulse.
- An msec of 0xFFFFFFFF passes through unchanged, with no wrap.
- Total latency from accept to wen_o is 2 cycles (accept in IDLE, then GRANT, then WRITE).

Test Plan:
- Single request: req0 with msec=5, mode=4'b0001 → wen_o pulses 2 cycles after accept with scratch=5 and mode=1. Drive rstn_pg_i low for 10 cycles → done_valid_o[0]=1 with err=0 one cycle after rstn_pg_i rises.
- Simultaneous requests: req0 and req1 both valid → req0 is granted. Req1 stays ungranted until the first transaction's DONE, then is accepted on the next IDLE cycle.
- Clamp: req1 with msec=0 → reg_scratch_o=MIN_SLEEP_MS=1.
- Timeout: hold rstn_pg_i=1 after the write → ERR at cycle ACK_TIMEOUT after WRITE; done_valid_o[owner]=1 with done_err_o=1; reg_pmu_en_o drops.
- Reset mid-SLEEPING: deassert rstn_i → all outputs 0, state IDLE, and no done pulse after reset is released.
- Spurious rstn_pg_i low while IDLE → no state change and busy_o=0.
